// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit: FSM encoding,
// decoder field positions and the PC step.
package fetch_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      ISSUE = 2'd2
   } fetch_state_t;

   localparam int INSTR_W  = 32;
   localparam int PC_STEP  = 4;

   localparam int COND_HI  = 31;
   localparam int COND_LO  = 28;
   localparam int OP_HI    = 27;
   localparam int OP_LO    = 26;
   localparam int FUNCT_HI = 25;
   localparam int FUNCT_LO = 20;
   localparam int RD_HI    = 15;
   localparam int RD_LO    = 12;

   typedef struct packed {
      logic [COND_HI-COND_LO:0]   cond;
      logic [OP_HI-OP_LO:0]       op;
      logic [FUNCT_HI-FUNCT_LO:0] func;
      logic [RD_HI-RD_LO:0]       rd;
   } instr_fields_t;

   function automatic instr_fields_t slice_fields(input logic [INSTR_W-1:0] word);
      instr_fields_t f;
      f.cond = word[COND_HI:COND_LO];
      f.op   = word[OP_HI:OP_LO];
      f.func = word[FUNCT_HI:FUNCT_LO];
      f.rd   = word[RD_HI:RD_LO];
      return f;
   endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between the fetch unit (master)
// and instruction memory (slave).
interface instr_fetch_unit_if
   import fetch_pkg::*;
#(
   parameter int ADDR_W = 32
);
   logic               imem_req;
   logic [ADDR_W-1:0]  imem_addr;
   logic               imem_ack;
   logic [INSTR_W-1:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ack,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ack,
      output imem_rdata
   );
endinterface

// File: rtl/instr_fetch_unit_pc_next_logic.sv
// Combinational next-PC path: sequential increment, R15 read value, word
// alignment of branch/result targets and misalignment detection.
module pc_next_logic
   import fetch_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic [ADDR_W-1:0] pc,
   input  logic              pcsrc,
   input  logic [ADDR_W-1:0] pc_target,
   output logic [ADDR_W-1:0] pc_plus8,
   output logic [ADDR_W-1:0] next_pc,
   output logic              target_misaligned
);
   logic [ADDR_W-1:0] pc_plus4;
   logic [ADDR_W-1:0] target_aligned;

   // Both increments wrap naturally at the top of the address space.
   assign pc_plus4          = pc + ADDR_W'(PC_STEP);
   assign pc_plus8          = pc + ADDR_W'(2 * PC_STEP);
   assign target_aligned    = {pc_target[ADDR_W-1:2], 2'b00};
   assign next_pc           = pcsrc ? target_aligned : pc_plus4;
   assign target_misaligned = pcsrc & (|pc_target[1:0]);
endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, fetches one instruction at a time over the imem
// bus and holds it with decoded fields until the datapath commits it.
module instr_fetch_unit
   import fetch_pkg::*;
#(
   parameter int                ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(32'h0000_0000)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   instr_fetch_unit_if.master   imem,
   input  logic                 halt,
   input  logic                 commit,
   input  logic                 pcsrc,
   input  logic [ADDR_W-1:0]    pc_target,
   output logic                 instr_valid,
   output logic [INSTR_W-1:0]   instr,
   output logic [3:0]           cond,
   output logic [1:0]           op,
   output logic [5:0]           func,
   output logic [3:0]           rd,
   output logic [ADDR_W-1:0]    pc,
   output logic [ADDR_W-1:0]    pc_plus8,
   output logic                 misalign_err
);
   fetch_state_t      state;
   logic [ADDR_W-1:0] next_pc;
   logic              target_misaligned;
   instr_fields_t     fields;

   pc_next_logic #(.ADDR_W(ADDR_W)) u_pc_next (
      .pc                (pc),
      .pcsrc             (pcsrc),
      .pc_target         (pc_target),
      .pc_plus8          (pc_plus8),
      .next_pc           (next_pc),
      .target_misaligned (target_misaligned)
   );

   // NOTE: every register below is assigned with <= so all of them update from
   // the same pre-edge values; blocking here would let later lines see new state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         pc             <= RESET_PC;
         imem.imem_req  <= 1'b0;
         imem.imem_addr <= RESET_PC;
         instr_valid    <= 1'b0;
         instr          <= '0;
         misalign_err   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (!halt) begin
                  state          <= FETCH;
                  imem.imem_req  <= 1'b1;
                  imem.imem_addr <= pc;
               end
            end
            FETCH: begin
               // halt is deliberately not looked at: a request is never abandoned.
               if (imem.imem_ack) begin
                  instr         <= imem.imem_rdata;
                  instr_valid   <= 1'b1;
                  imem.imem_req <= 1'b0;
                  state         <= ISSUE;
               end
            end
            ISSUE: begin
               if (commit) begin
                  instr_valid  <= 1'b0;
                  pc           <= next_pc;
                  misalign_err <= misalign_err | target_misaligned;
                  if (!halt) begin
                     state          <= FETCH;
                     imem.imem_req  <= 1'b1;
                     imem.imem_addr <= next_pc;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            default: begin
               state         <= IDLE;
               imem.imem_req <= 1'b0;
               instr_valid   <= 1'b0;
            end
         endcase
      end
   end

   // Fields read as zero whenever nothing valid is being issued.
   assign fields = instr_valid ? slice_fields(instr) : '0;
   assign cond   = fields.cond;
   assign op     = fields.op;
   assign func   = fields.func;
   assign rd     = fields.rd;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench: randomized memory latency and commit decisions, with a
// program-flow model feeding a scoreboard that a separate monitor drains.
module tb_instr_fetch_unit;
   import fetch_pkg::*;

   localparam int          ADDR_W   = 32;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        halt, commit, pcsrc;
   logic [31:0] pc_target;
   logic        instr_valid;
   logic [31:0] instr;
   logic [3:0]  cond;
   logic [1:0]  op;
   logic [5:0]  func;
   logic [3:0]  rd;
   logic [31:0] pc, pc_plus8;
   logic        misalign_err;

   instr_fetch_unit_if #(.ADDR_W(ADDR_W)) bus ();

   instr_fetch_unit #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .imem         (bus.master),
      .halt         (halt),
      .commit       (commit),
      .pcsrc        (pcsrc),
      .pc_target    (pc_target),
      .instr_valid  (instr_valid),
      .instr        (instr),
      .cond         (cond),
      .op           (op),
      .func         (func),
      .rd           (rd),
      .pc           (pc),
      .pc_plus8     (pc_plus8),
      .misalign_err (misalign_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] word;
      logic        mis;
   } exp_t;

   typedef struct {
      int          exec;
      logic        pcsrc;
      logic [31:0] target;
      logic        halt;
      logic        pulse;
   } dec_t;

   exp_t        exp_q[$];
   int          lat_q[$];
   int          checks   = 0;
   int          failures = 0;
   logic [31:0] model_pc;
   logic        model_mis;
   logic        stray_ack = 1'b0;

   // Program image: address 0 holds a known ARM-style word, the rest is hashed.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h0) return 32'hE280_1005;
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Instruction memory: variable latency, plus an injectable stray ack.
   initial begin : responder
      int          lat;
      logic [31:0] ea;
      bus.imem_ack   = 1'b0;
      bus.imem_rdata = '0;
      forever begin
         @(negedge clk);
         bus.imem_ack   = stray_ack;
         bus.imem_rdata = stray_ack ? 32'hDEAD_BEEF : 32'h0;
         if (bus.imem_req && rst_n) begin
            lat = (lat_q.size() != 0) ? lat_q.pop_front() : int'($urandom_range(0, 5));
            ea  = (exp_q.size() != 0) ? exp_q[0].pc : 32'hxxxx_xxxx;
            check("fetch_addr", bus.imem_addr, ea);
            for (int i = 0; i < lat; i++) begin
               @(negedge clk);
               if (!bus.imem_req) break;
               check("addr_stable", bus.imem_addr, ea);
            end
            if (bus.imem_req) begin
               bus.imem_ack   = 1'b1;
               bus.imem_rdata = mem_word(bus.imem_addr);
            end
         end
      end
   end

   // Monitor: each newly valid instruction is compared with the scoreboard head.
   initial begin : monitor
      logic seen;
      exp_t e;
      seen = 1'b0;
      forever begin
         @(negedge clk);
         if (!instr_valid || !rst_n) begin
            seen = 1'b0;
         end else if (!seen) begin
            seen = 1'b1;
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_instr: got pc %h with empty scoreboard", pc);
            end else begin
               e = exp_q.pop_front();
               check("pc",           pc,                 e.pc);
               check("instr",        instr,              e.word);
               check("cond",         32'(cond),          32'(e.word[31:28]));
               check("op",           32'(op),            32'(e.word[27:26]));
               check("func",         32'(func),          32'(e.word[25:20]));
               check("rd",           32'(rd),            32'(e.word[15:12]));
               check("pc_plus8",     pc_plus8,           e.pc + 32'd8);
               check("misalign_err", 32'(misalign_err),  32'(e.mis));
            end
         end
      end
   end

   task automatic run_one(input dec_t d);
      int          waited = 0;
      logic [31:0] prev_word;
      while (!instr_valid && waited < 60) begin
         @(negedge clk);
         waited++;
      end
      if (!instr_valid) begin
         checks++;
         failures++;
         $display("FAIL instr_valid_timeout: got no instr after %0d cycles, expected pc %h", waited, model_pc);
         return;
      end
      repeat (d.exec) @(negedge clk);

      prev_word = mem_word(model_pc);
      commit    = 1'b1;
      pcsrc     = d.pcsrc;
      pc_target = d.target;
      halt      = d.halt;
      model_pc  = d.pcsrc ? (d.target & ~32'd3) : model_pc + 32'd4;
      model_mis = model_mis | (d.pcsrc && (d.target % 4) != 0);
      exp_q.push_back('{model_pc, mem_word(model_pc), model_mis});

      @(posedge clk); #1;
      commit    = 1'b0;
      pcsrc     = 1'b0;
      pc_target = $urandom;
      check("valid_drop",       32'(instr_valid), 32'd0);
      check("fields_gated",     32'({cond, op, func, rd}), 32'd0);
      check("pc_update",        pc, model_pc);
      check("misalign_commit",  32'(misalign_err), 32'(model_mis));
      check("req_after_commit", 32'(bus.imem_req), 32'(!d.halt));
      if (!d.halt) check("addr_after_commit", bus.imem_addr, model_pc);

      if (d.halt) begin
         repeat (2) @(posedge clk);
         #1;
         check("idle_no_req", 32'(bus.imem_req), 32'd0);
         commit    = 1'b1;
         pcsrc     = 1'b1;
         pc_target = 32'h0000_0041;
         stray_ack = 1'b1;
         @(posedge clk); #1;
         commit    = 1'b0;
         pcsrc     = 1'b0;
         stray_ack = 1'b0;
         @(posedge clk); #1;
         check("idle_pc",       pc, model_pc);
         check("idle_misalign", 32'(misalign_err), 32'(model_mis));
         check("idle_valid",    32'(instr_valid), 32'd0);
         check("idle_instr",    instr, prev_word);
         check("idle_req",      32'(bus.imem_req), 32'd0);
         halt = 1'b0;
         @(posedge clk); #1;
         check("restart_req",  32'(bus.imem_req), 32'd1);
         check("restart_addr", bus.imem_addr, model_pc);
      end else if (d.pulse) begin
         halt = 1'b1;
         repeat (2) @(posedge clk);
         #1;
         halt = 1'b0;
      end
   endtask

   initial begin : stimulus
      dec_t dir [6];
      dec_t d;
      int   waited;

      rst_n     = 1'b0;
      halt      = 1'b0;
      commit    = 1'b0;
      pcsrc     = 1'b0;
      pc_target = '0;
      model_pc  = RESET_PC;
      model_mis = 1'b0;
      lat_q     = '{1, 0, 5};

      #12;
      check("rst_req",      32'(bus.imem_req), 32'd0);
      check("rst_addr",     bus.imem_addr, RESET_PC);
      check("rst_valid",    32'(instr_valid), 32'd0);
      check("rst_instr",    instr, 32'd0);
      check("rst_misalign", 32'(misalign_err), 32'd0);
      check("rst_pc",       pc, RESET_PC);
      check("rst_pc_plus8", pc_plus8, RESET_PC + 32'd8);
      exp_q.push_back('{RESET_PC, mem_word(RESET_PC), 1'b0});
      @(negedge clk);
      rst_n = 1'b1;

      // Directed walk: jump, sequential step, misaligned jump, wrap, halt.
      dir[0] = '{2, 1'b1, 32'h0000_0010, 1'b0, 1'b0};
      dir[1] = '{1, 1'b0, 32'h0000_0000, 1'b0, 1'b1};
      dir[2] = '{0, 1'b1, 32'h0000_0102, 1'b0, 1'b0};
      dir[3] = '{3, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0};
      dir[4] = '{1, 1'b0, 32'h0000_0000, 1'b0, 1'b0};
      dir[5] = '{1, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
      for (int n = 0; n < 6; n++) run_one(dir[n]);

      for (int n = 0; n < 120; n++) begin
         d.exec   = int'($urandom_range(0, 3));
         d.pcsrc  = ($urandom_range(0, 1) == 1);
         d.target = $urandom;
         if ($urandom_range(0, 7) != 0) d.target[1:0] = 2'b00;
         d.halt   = ($urandom_range(0, 9) == 0);
         d.pulse  = ($urandom_range(0, 5) == 0);
         run_one(d);
      end

      // Reset while a slow fetch is outstanding.
      lat_q.push_back(8);
      d = '{1, 1'b0, 32'h0, 1'b1, 1'b0};
      run_one(d);
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      check("reset_drops_req", 32'(bus.imem_req), 32'd0);
      check("reset_pc",        pc, RESET_PC);
      check("reset_addr",      bus.imem_addr, RESET_PC);
      check("reset_misalign",  32'(misalign_err), 32'd0);
      exp_q.delete();
      model_pc  = RESET_PC;
      model_mis = 1'b0;
      exp_q.push_back('{RESET_PC, mem_word(RESET_PC), 1'b0});
      @(negedge clk);
      rst_n = 1'b1;

      d = '{2, 1'b1, 32'h0000_0200, 1'b0, 1'b0};
      run_one(d);

      waited = 0;
      while (exp_q.size() != 0 && waited < 60) begin
         @(negedge clk);
         waited++;
      end
      @(negedge clk);
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
